march_element_sequencer: RTL and testbench

Executes one march element held in the instruction register: walks the address space up or down and, at every address, issues the element's list of single read/write operations to the memory under test. It sits directly downstream of `instruction_register`, consuming its `updwn`/`op`/`pol`/`data` fields. While an element runs, it freezes that register through `hold_out`. It feeds the memory port and the response comparator.

---
 rtl/march_element_sequencer_pkg.sv | 7 +
 rtl/march_element_sequencer_if.sv | 43 ++++
 rtl/march_element_sequencer_addr_counter.sv | 21 ++
 rtl/march_element_sequencer.sv | 85 ++++++++
 tb/tb_march_element_sequencer.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/march_element_sequencer_pkg.sv
// march_element_sequencer_pkg: shared op codes, width defaults and FSM state encodings
package march_element_sequencer_pkg;
    localparam int NOPS_DEF = 4;
    localparam int OPW_DEF  = 4;
    typedef enum logic [3:0] {OP_NOP = 4'd0, OP_WR = 4'd1, OP_RD = 4'd2} op_e;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/march_element_sequencer_if.sv
// march_element_sequencer_if: instruction-register fields in, memory/comparator strobes out
// master: sequencer side (takes start/updwn_in/op_in/op_cnt_in/pol_in/data_in, drives hold_out/busy/mem_*/cmp_en/exp_data/elem_done)
// slave: environment side, directions mirrored
// PMBIST_ADDR_LIMIT_EN adds addr_last_in (last address of the walk)
interface march_element_sequencer_if #(
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int NOPS = 4,
    parameter int OPW  = 4
);
    logic                     start;
    logic                     updwn_in;
    logic [NOPS*OPW-1:0]      op_in;
    logic [$clog2(NOPS)-1:0]  op_cnt_in;
    logic [NOPS-1:0]          pol_in;
    logic [DW-1:0]            data_in;
`ifdef PMBIST_ADDR_LIMIT_EN
    logic [AW-1:0]            addr_last_in;
`endif
    logic                     hold_out;
    logic                     busy;
    logic [AW-1:0]            mem_addr;
    logic                     mem_we;
    logic                     mem_re;
    logic [DW-1:0]            mem_wdata;
    logic                     cmp_en;
    logic [DW-1:0]            exp_data;
    logic                     elem_done;
    modport master (
        input  start, updwn_in, op_in, op_cnt_in, pol_in, data_in,
`ifdef PMBIST_ADDR_LIMIT_EN
        input  addr_last_in,
`endif
        output hold_out, busy, mem_addr, mem_we, mem_re, mem_wdata, cmp_en, exp_data, elem_done
    );
    modport slave (
        output start, updwn_in, op_in, op_cnt_in, pol_in, data_in,
`ifdef PMBIST_ADDR_LIMIT_EN
        output addr_last_in,
`endif
        input  hold_out, busy, mem_addr, mem_we, mem_re, mem_wdata, cmp_en, exp_data, elem_done
    );
endinterface

// File: rtl/march_element_sequencer_addr_counter.sv
// march_addr_counter: loadable up/down address counter flagging the terminal address
// load: count <= updwn ? 0 : last; step: count +/- 1; at_end: count is the terminal value for updwn
module march_addr_counter #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic          updwn,
    input  logic [AW-1:0] last,
    output logic [AW-1:0] addr,
    output logic          at_end
);
    assign at_end = addr == (updwn ? last : '0);
    always_ff @(posedge clk) begin
        if (!rst_n) addr <= '0;
        else if (load) addr <= updwn ? '0 : last;
        else if (step) addr <= updwn ? addr + 1'b1 : addr - 1'b1;
    end
endmodule

// File: rtl/march_element_sequencer.sv
// march_element_sequencer: runs one march element over the address space, one single op per cycle
// clk/rst_n (sync, active-low); bus: march_element_sequencer_if.master
// PMBIST_ADDR_LIMIT_EN: last address comes from addr_last_in (captured on start) instead of 2^AW-1
module march_element_sequencer
    import march_element_sequencer_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int NOPS = NOPS_DEF,
    parameter int OPW  = OPW_DEF
) (
    input logic                       clk,
    input logic                       rst_n,
    march_element_sequencer_if.master bus
);
    localparam int CW = $clog2(NOPS);
    state_t         state, state_nx;
    logic [CW-1:0]  idx, idx_nx;
    logic [AW-1:0]  addr, last;
    logic [OPW-1:0] cur_op;
    logic [DW-1:0]  cur_data, rexp;
    logic           is_run, last_op, at_end, load, step, is_wr, is_rd;
    assign is_run   = state == RUN;
    assign cur_op   = bus.op_in[idx*OPW +: OPW];
    assign cur_data = bus.data_in ^ {DW{bus.pol_in[idx]}};
    assign last_op  = idx == bus.op_cnt_in;
    assign is_wr    = is_run && cur_op == OPW'(OP_WR);
    assign is_rd    = is_run && cur_op == OPW'(OP_RD);
    assign load     = state == IDLE && bus.start;
    // terminal check comes before stepping so the address never wraps
    assign step     = is_run && last_op && !at_end;
`ifdef PMBIST_ADDR_LIMIT_EN
    logic [AW-1:0] last_q;
    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= '0;
        else if (load) last_q <= bus.addr_last_in;
    end
    // the live value is needed on the load edge for a descending start address
    assign last = load ? bus.addr_last_in : last_q;
`else
    assign last = '1;
`endif
    march_addr_counter #(.AW(AW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .updwn (bus.updwn_in),
        .last  (last),
        .addr  (addr),
        .at_end(at_end)
    );
    assign bus.hold_out  = bus.start | is_run;
    assign bus.busy      = state != IDLE;
    assign bus.elem_done = state == DONE;
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        state_nx = load ? RUN : (is_run && last_op && at_end) ? DONE : (state == DONE) ? IDLE : state;
        idx_nx   = (!is_run || last_op) ? '0 : idx + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            rexp          <= '0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_wdata <= '0;
            bus.cmp_en    <= 1'b0;
            bus.exp_data  <= '0;
        end else begin
            state         <= state_nx;
            idx           <= idx_nx;
            rexp          <= is_rd ? cur_data : '0;
            bus.mem_addr  <= is_run ? addr : '0;
            bus.mem_we    <= is_wr;
            bus.mem_re    <= is_rd;
            bus.mem_wdata <= is_wr ? cur_data : '0;
            bus.cmp_en    <= bus.mem_re;
            bus.exp_data  <= rexp;
        end
    end
endmodule

// File: tb/tb_march_element_sequencer.sv
// tb_march_element_sequencer: scoreboard bench for march_element_sequencer at AW=3
module tb_march_element_sequencer;
    typedef struct packed {
        logic       we;
        logic       re;
        logic [2:0] addr;
        logic [7:0] d;
    } op_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    op_t  q[$];
    logic exp_rd = 1'b0;
    logic [7:0] exp_v = '0;
    march_element_sequencer_if #(.AW(3), .DW(8), .NOPS(4), .OPW(4)) bus ();
    march_element_sequencer #(.AW(3), .DW(8), .NOPS(4), .OPW(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        op_t e;
        if (exp_rd) chk("exp_data", bus.exp_data, exp_v);
        if (bus.cmp_en || exp_rd) chk("cmp_en", bus.cmp_en, exp_rd);
        exp_rd = 1'b0;
        if (bus.mem_we || bus.mem_re) begin
            if (q.size() == 0) chk("unexpected_op", {bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata}, '0);
            else begin
                e = q.pop_front();
                chk("op", {bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00},
                    {e.we, e.re, e.addr, e.we ? e.d : 8'h00});
                exp_rd = e.re;
                exp_v  = e.d;
            end
        end
    end

    task automatic push_exp(input logic up, input logic [15:0] ops, input logic [1:0] cnt,
                            input logic [3:0] pol, input logic [7:0] data, input int last);
        logic [3:0] code;
        for (int a = 0; a <= last; a++)
            for (int k = 0; k <= int'(cnt); k++) begin
                code = ops[k*4 +: 4];
                if (code == 4'd1 || code == 4'd2)
                    q.push_back('{we: code == 4'd1, re: code == 4'd2,
                                  addr: 3'(up ? a : last - a), d: data ^ {8{pol[k]}}});
            end
    endtask

    task automatic kick(input logic up, input logic [15:0] ops, input logic [1:0] cnt,
                        input logic [3:0] pol, input logic [7:0] data, input int last);
        @(negedge clk);
        bus.updwn_in  = up;
        bus.op_in     = ops;
        bus.op_cnt_in = cnt;
        bus.pol_in    = pol;
        bus.data_in   = data;
`ifdef PMBIST_ADDR_LIMIT_EN
        bus.addr_last_in = 3'(last);
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_elem(input logic up, input logic [15:0] ops, input logic [1:0] cnt,
                            input logic [3:0] pol, input logic [7:0] data, input int last, input int rp);
        int cyc = 0;
        int hold_bad = 0;
        push_exp(up, ops, cnt, pol, data, last);
        kick(up, ops, cnt, pol, data, last);
        chk("busy_hold_run", {bus.busy, bus.hold_out}, 2'b11);
        while (!bus.elem_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.start = cyc == rp;
            if (!bus.elem_done && !bus.hold_out) hold_bad++;
        end
        bus.start = 1'b0;
        chk("run_cycles", cyc, (last + 1) * (int'(cnt) + 1));
        chk("hold_in_run", hold_bad, 0);
        chk("done_state", {bus.elem_done, bus.busy, bus.hold_out}, 3'b110);
        @(negedge clk);
        chk("idle_after", {bus.elem_done, bus.busy}, 2'b00);
        repeat (2) @(negedge clk);
        chk("sb_empty", q.size(), 0);
    endtask

    initial begin
        int seen;
        bus.start = 1'b0;
        bus.updwn_in = 1'b0;
        bus.op_in = '0;
        bus.op_cnt_in = '0;
        bus.pol_in = '0;
        bus.data_in = '0;
`ifdef PMBIST_ADDR_LIMIT_EN
        bus.addr_last_in = 3'd7;
`endif
        repeat (2) @(negedge clk);
        chk("reset_outs", {bus.busy, bus.hold_out, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata,
                           bus.cmp_en, bus.exp_data, bus.elem_done}, '0);
        rst_n = 1'b1;
        run_elem(1'b1, 16'h0001, 2'd0, 4'b0000, 8'hA5, 7, 0);
        run_elem(1'b0, 16'h0021, 2'd1, 4'b0010, 8'h00, 7, 0);
        run_elem(1'b1, 16'h02F1, 2'd2, 4'b0100, 8'h3C, 7, 0);
        run_elem(1'b1, 16'h0012, 2'd1, 4'b0001, 8'h5A, 7, 5);
        push_exp(1'b1, 16'h0001, 2'd0, 4'b0000, 8'h11, 7);
        kick(1'b1, 16'h0001, 2'd0, 4'b0000, 8'h11, 7);
        seen = 0;
        while (!(bus.mem_we && bus.mem_addr == 3'd3) && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        chk("reached_addr3", {bus.mem_we, bus.mem_addr}, {1'b1, 3'd3});
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outs", {bus.busy, bus.hold_out, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata,
                           bus.cmp_en, bus.exp_data, bus.elem_done}, '0);
        q.delete();
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.elem_done || bus.busy) seen++;
        end
        chk("no_done_after_abort", seen, 0);
        run_elem(1'b1, 16'h0001, 2'd0, 4'b0000, 8'h22, 7, 0);
`ifdef PMBIST_ADDR_LIMIT_EN
        run_elem(1'b1, 16'h0002, 2'd0, 4'b0000, 8'h77, 0, 0);
        run_elem(1'b0, 16'h0021, 2'd1, 4'b0000, 8'h96, 2, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
